serial_disp_tx: RTL and testbench

//   Parallel-to-serial transmitter driving the board's external 74HC595-style shift-register chain

---
 rtl/serial_disp_tx_if.sv | 34 +++
 rtl/serial_disp_tx.sv | 175 +++++++++++++++++
 tb/tb_serial_disp_tx.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_disp_tx_if.sv
// serial_disp_tx_if
//   Bundles the request side (start/data/busy/done) and the serial pins
//   (sclk/sdat/latch) of the shift-register-chain transmitter.
//   master : display/GPIO logic that requests transfers and watches the pins
//   slave  : the transmitter itself
//   Ports (all carried as interface signals):
//     start  request a transfer
//     data   DATA_BITS-wide pattern
//     busy   transfer in flight
//     done   one-cycle completion pulse
//     sclk   serial clock to the chain
//     sdat   serial data to the chain
//     latch  storage-register strobe to the chain
interface serial_disp_tx_if #(
    parameter int DATA_BITS = 64
);
    logic                 start;
    logic [DATA_BITS-1:0] data;
    logic                 busy;
    logic                 done;
    logic                 sclk;
    logic                 sdat;
    logic                 latch;

    modport master (
        output start, data,
        input  busy, done, sclk, sdat, latch
    );

    modport slave (
        input  start, data,
        output busy, done, sclk, sdat, latch
    );
endinterface

// File: rtl/serial_disp_tx.sv
// serial_disp_tx
//   Parallel-to-serial transmitter for the external 74HC595-style chain that
//   drives the LEDs and seven-segment digits. A pattern is captured on an
//   accepted start, shifted out on sdat/sclk, then a latch strobe makes the
//   chain update all of its outputs at once.
//   Parameters:
//     DATA_BITS  bits per transfer (>=2)
//     DIV        clk cycles per sclk half-period (>=1)
//     MSB_FIRST  1: data[DATA_BITS-1] goes out first, 0: data[0] first
//   Ports:
//     clk   system clock, rising edge
//     rst   asynchronous reset, active-high
//     bus   serial_disp_tx_if.slave (start/data in; busy/done/sclk/sdat/latch out)
//   Every output comes straight from a flop: nothing combinational reaches the pins.
module serial_disp_tx #(
    parameter int DATA_BITS = 64,
    parameter int DIV       = 2,
    parameter bit MSB_FIRST = 1'b1
) (
    input logic              clk,
    input logic              rst,
    serial_disp_tx_if.slave  bus
);
    localparam int CNT_W = $clog2(DATA_BITS + 1);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_LATCH,
        ST_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic                 sclk_q, sclk_d;
    logic                 sdat_q, sdat_d;
    logic                 latch_q, latch_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    // Bit ordering is fixed at elaboration, so these reduce to plain wiring.
    logic                 first_bit;
    logic                 next_bit;
    logic [DATA_BITS-1:0] shreg_adv;

    always_comb begin
        if (MSB_FIRST) begin
            first_bit = bus.data[DATA_BITS-1];
            next_bit  = shreg_q[DATA_BITS-2];
            shreg_adv = {shreg_q[DATA_BITS-2:0], 1'b0};
        end else begin
            first_bit = bus.data[0];
            next_bit  = shreg_q[1];
            shreg_adv = {1'b0, shreg_q[DATA_BITS-1:1]};
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can leave
    // one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        sclk_d  = sclk_q;
        sdat_d  = sdat_q;
        latch_d = latch_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (bus.start) begin
                    shreg_d = bus.data;
                    cnt_d   = CNT_LOAD;
                    div_d   = '0;
                    sclk_d  = 1'b0;
                    sdat_d  = first_bit;
                    busy_d  = 1'b1;
                    state_d = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        // End of the high phase: sdat only moves together with
                        // the falling sclk, so it is settled at every rising edge.
                        sclk_d = 1'b0;
                        if (cnt_q == CNT_LAST) begin
                            cnt_d   = '0;
                            sdat_d  = 1'b0;
                            latch_d = 1'b1;
                            state_d = ST_LATCH;
                        end else begin
                            shreg_d = shreg_adv;
                            sdat_d  = next_bit;
                            cnt_d   = cnt_q - 1'b1;
                        end
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end

            ST_LATCH: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    latch_d = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end

            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                sclk_d  = 1'b0;
                sdat_d  = 1'b0;
                latch_d = 1'b0;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    // The shift register is cleared on reset too: it is a handful of flops, not
    // a memory, and a clean value keeps the idle pins deterministic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            div_q   <= '0;
            sclk_q  <= 1'b0;
            sdat_q  <= 1'b0;
            latch_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            sclk_q  <= sclk_d;
            sdat_q  <= sdat_d;
            latch_q <= latch_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.sclk  = sclk_q;
    assign bus.sdat  = sdat_q;
    assign bus.latch = latch_q;
endmodule

// File: tb/tb_serial_disp_tx.sv
// tb_serial_disp_tx
//   Directed bench for serial_disp_tx. Three instances share clk/rst:
//     index 0: DATA_BITS=8,  DIV=1, MSB first
//     index 1: DATA_BITS=8,  DIV=1, LSB first
//     index 2: default parameters (64 bits, DIV=2, MSB first)
//   A negedge monitor rebuilds the serial stream from sdat at each sclk rise
//   and counts busy/done/latch cycles; expected values are hand-computed.
module tb_serial_disp_tx;
    logic clk;
    logic rst;

    serial_disp_tx_if #(.DATA_BITS(8))  if8m ();
    serial_disp_tx_if #(.DATA_BITS(8))  if8l ();
    serial_disp_tx_if #(.DATA_BITS(64)) if64 ();

    serial_disp_tx #(.DATA_BITS(8), .DIV(1), .MSB_FIRST(1'b1)) u_dut8m (
        .clk (clk),
        .rst (rst),
        .bus (if8m.slave)
    );

    serial_disp_tx #(.DATA_BITS(8), .DIV(1), .MSB_FIRST(1'b0)) u_dut8l (
        .clk (clk),
        .rst (rst),
        .bus (if8l.slave)
    );

    serial_disp_tx u_dut64 (
        .clk (clk),
        .rst (rst),
        .bus (if64.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] busy_v, done_v, sclk_v, sdat_v, latch_v;
    assign busy_v  = {if64.busy,  if8l.busy,  if8m.busy};
    assign done_v  = {if64.done,  if8l.done,  if8m.done};
    assign sclk_v  = {if64.sclk,  if8l.sclk,  if8m.sclk};
    assign sdat_v  = {if64.sdat,  if8l.sdat,  if8m.sdat};
    assign latch_v = {if64.latch, if8l.latch, if8m.latch};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int div_of(input int i);
        return (i == 2) ? 2 : 1;
    endfunction

    // ---------------- monitor ----------------
    logic        mon_clr = 1'b0;
    logic [2:0]  prev_sclk, prev_sdat, prev_latch;
    logic [63:0] stream     [3];
    int          nbits      [3];
    int          busy_cnt   [3];
    int          done_cnt   [3];
    int          done_at    [3];
    int          latch_cnt  [3];
    int          latch_bits [3];
    int          glitch     [3];
    int          per_bad    [3];
    int          last_rise  [3];
    int          cyc = 0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 3; i++) begin
            if (mon_clr) begin
                stream[i]     <= '0;
                nbits[i]      <= 0;
                busy_cnt[i]   <= 0;
                done_cnt[i]   <= 0;
                done_at[i]    <= 0;
                latch_cnt[i]  <= 0;
                latch_bits[i] <= 0;
                glitch[i]     <= 0;
                per_bad[i]    <= 0;
                last_rise[i]  <= 0;
            end else begin
                if (sclk_v[i] && !prev_sclk[i]) begin
                    stream[i] <= {stream[i][62:0], sdat_v[i]};
                    nbits[i]  <= nbits[i] + 1;
                    if (nbits[i] > 0 && (cyc - last_rise[i]) != 2 * div_of(i))
                        per_bad[i] <= per_bad[i] + 1;
                    last_rise[i] <= cyc;
                end
                if (sclk_v[i] && prev_sclk[i] && (sdat_v[i] != prev_sdat[i]))
                    glitch[i] <= glitch[i] + 1;
                if (busy_v[i])
                    busy_cnt[i] <= busy_cnt[i] + 1;
                if (done_v[i]) begin
                    done_cnt[i] <= done_cnt[i] + 1;
                    done_at[i]  <= busy_cnt[i] + (busy_v[i] ? 1 : 0);
                end
                if (latch_v[i])
                    latch_cnt[i] <= latch_cnt[i] + 1;
                if (latch_v[i] && !prev_latch[i])
                    latch_bits[i] <= nbits[i];
            end
        end
        prev_sclk  <= sclk_v;
        prev_sdat  <= sdat_v;
        prev_latch <= latch_v;
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_req(input int i, input logic s, input logic [63:0] d);
        case (i)
            0:       begin if8m.start = s; if8m.data = d[7:0]; end
            1:       begin if8l.start = s; if8l.data = d[7:0]; end
            default: begin if64.start = s; if64.data = d;      end
        endcase
    endtask

    task automatic clr_mon();
        mon_clr = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 mon_clr = 1'b0;
    endtask

    // One-cycle start pulse; returns just after the accepting edge.
    task automatic xfer(input int i, input logic [63:0] d);
        @(posedge clk);
        #1 set_req(i, 1'b1, d);
        @(posedge clk);
        #1 set_req(i, 1'b0, d);
    endtask

    task automatic wait_idle(input int i, input int budget, input string tag);
        bit ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (!busy_v[i]) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_timeout"}, 64'(ok), 64'd1);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        rst = 1'b1;
        set_req(0, 1'b0, '0);
        set_req(1, 1'b0, '0);
        set_req(2, 1'b0, '0);

        // Reset: outputs forced low immediately, and they stay low with start=0.
        #1 check("rst_async", 64'({busy_v, done_v, sclk_v, sdat_v, latch_v}), 64'd0);
        #12 rst = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_idle", 64'({busy_v, done_v, sclk_v, sdat_v, latch_v}), 64'd0);

        // 8 bits, MSB first, A5.
        clr_mon();
        xfer(0, 64'hA5);
        wait_idle(0, 40, "a5");
        check("a5_stream",     stream[0][7:0],      64'hA5);
        check("a5_nbits",      64'(nbits[0]),       64'd8);
        check("a5_busy",       64'(busy_cnt[0]),    64'd18);
        check("a5_done_cnt",   64'(done_cnt[0]),    64'd1);
        check("a5_done_at",    64'(done_at[0]),     64'd18);
        check("a5_latch_cnt",  64'(latch_cnt[0]),   64'd1);
        check("a5_latch_bits", 64'(latch_bits[0]),  64'd8);
        check("a5_sdat_glitch",64'(glitch[0]),      64'd0);

        // 8 bits, LSB first, 01: first bit 1, then seven zeros.
        clr_mon();
        xfer(1, 64'h01);
        wait_idle(1, 40, "lsb");
        check("lsb_stream",    stream[1][7:0],      64'h80);
        check("lsb_nbits",     64'(nbits[1]),       64'd8);
        check("lsb_busy",      64'(busy_cnt[1]),    64'd18);

        // Default parameters, 64-bit pattern.
        clr_mon();
        xfer(2, 64'hFEDC_BA98_7654_3210);
        wait_idle(2, 300, "w64");
        check("w64_stream",    stream[2],           64'hFEDC_BA98_7654_3210);
        check("w64_nbits",     64'(nbits[2]),       64'd64);
        check("w64_busy",      64'(busy_cnt[2]),    64'd259);
        check("w64_done_cnt",  64'(done_cnt[2]),    64'd1);
        check("w64_done_at",   64'(done_at[2]),     64'd259);
        check("w64_latch_cnt", 64'(latch_cnt[2]),   64'd2);
        check("w64_period",    64'(per_bad[2]),     64'd0);
        check("w64_sdat_glitch",64'(glitch[2]),     64'd0);

        // start and data changes while busy are ignored.
        clr_mon();
        xfer(0, 64'hA5);
        repeat (5) @(posedge clk);
        #1 set_req(0, 1'b1, 64'hFF);
        @(posedge clk);
        #1 set_req(0, 1'b0, 64'hFF);
        wait_idle(0, 40, "ign");
        repeat (4) @(negedge clk);
        check("ign_no_restart", 64'(busy_v[0]),     64'd0);
        check("ign_stream",    stream[0][7:0],      64'hA5);
        check("ign_done_cnt",  64'(done_cnt[0]),    64'd1);
        check("ign_busy",      64'(busy_cnt[0]),    64'd18);

        // start held high: back-to-back transfers, one idle cycle apart,
        // each using the data present on its own accept edge.
        clr_mon();
        @(posedge clk);
        #1 set_req(0, 1'b1, 64'h5A);
        @(posedge clk);
        #1 set_req(0, 1'b1, 64'hC3);
        wait_idle(0, 40, "b2b1");
        @(negedge clk);
        check("b2b_gap",       64'(busy_v[0]),      64'd1);
        set_req(0, 1'b0, 64'hC3);
        wait_idle(0, 40, "b2b2");
        check("b2b_stream",    stream[0][15:0],     64'h5AC3);
        check("b2b_done_cnt",  64'(done_cnt[0]),    64'd2);
        check("b2b_busy",      64'(busy_cnt[0]),    64'd36);

        // Reset mid-transfer after three bits: abort with no latch/done.
        clr_mon();
        xfer(0, 64'hFF);
        begin
            bit reached = 1'b0;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                if (nbits[0] >= 3) begin
                    reached = 1'b1;
                    break;
                end
            end
            check("abort_reach3", 64'(reached), 64'd1);
        end
        #2 rst = 1'b1;
        #1 check("abort_outs", 64'({busy_v[0], done_v[0], sclk_v[0], sdat_v[0], latch_v[0]}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("abort_no_done",  64'(done_cnt[0]),   64'd0);
        check("abort_no_latch", 64'(latch_cnt[0]),  64'd0);
        check("abort_idle",     64'(busy_v[0]),     64'd0);

        clr_mon();
        xfer(0, 64'h3C);
        wait_idle(0, 40, "post");
        check("post_stream",    stream[0][7:0],     64'h3C);
        check("post_nbits",     64'(nbits[0]),      64'd8);
        check("post_done_cnt",  64'(done_cnt[0]),   64'd1);
        check("post_latch_cnt", 64'(latch_cnt[0]),  64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
